// File: rtl/xvga_defs.sv
// Shared raster definitions for the 1024x768@60 display: default timing,
// derived totals, beam counter widths and the wall codes latched on vblank.
package xvga_defs;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 160;
  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF     = 3;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 29;

  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  // Wall codes the physics block latches when vblank_start pulses.
  typedef enum logic [2:0] {
    NO_WALL     = 3'd0,
    LEFT_WALL   = 3'd1,
    RIGHT_WALL  = 3'd2,
    TOP_WALL    = 3'd3,
    BOTTOM_WALL = 3'd4,
    FRONT_WALL  = 3'd5
  } wall_t;

  // Half-open window test lo <= pos < hi, unsigned at counter width.
  function automatic logic in_window(input logic [10:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that lines sync/blank up with the registered
// sprite pixel pipeline. DEPTH=0 degenerates to a wire.
module sync_delay #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_s;
      // Clock and reset have no role in the pass-through variant.
      assign unused_s = clk ^ reset_n;
      assign dout     = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift the sync/blank vector one stage per clock; reset fills every stage.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RESET_VAL;
          end
        end else begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/xvga_timing.sv
// Raster timing generator: beam counters, sync/blank registered from the next
// count so they line up with hcount/vcount, frame strobes and a frame counter.
module xvga_timing
  import xvga_defs::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic                vclock,
  input  logic                reset_n,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hsync,
  output logic                vsync,
  output logic                blank,
  output logic                hsync_d,
  output logic                vsync_d,
  output logic                blank_d,
  output logic                frame_start,
  output logic                vblank_start,
  output logic [7:0]          frame_count
);

  localparam logic [10:0] H_LAST_C   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_ACT_C    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START_C = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END_C   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST_C   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [10:0] VS_START_C = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END_C   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  FILL_C     = {~SYNC_POL, ~SYNC_POL, 1'b1};

  logic [10:0] hcount_r;
  logic [9:0]  vcount_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        blank_r;
  logic        frame_start_r;
  logic        vblank_start_r;
  logic [7:0]  frame_count_r;

  logic [10:0] hcount_next_s;
  logic [9:0]  vcount_next_s;
  logic        h_wrap_s;
  logic        v_wrap_s;
  logic [2:0]  delayed_s;

  // Next beam position: hcount wraps at end of line and carries into vcount.
  always_comb begin
    h_wrap_s      = (hcount_r == H_LAST_C);
    v_wrap_s      = (vcount_r == V_LAST_C);
    hcount_next_s = hcount_r + 11'd1;
    vcount_next_s = vcount_r;
    if (h_wrap_s) begin
      hcount_next_s = 11'd0;
      if (v_wrap_s) begin
        vcount_next_s = 10'd0;
      end else begin
        vcount_next_s = vcount_r + 10'd1;
      end
    end else begin
      vcount_next_s = vcount_r;
    end
  end

  // Counters, sync/blank decoded from the next position, strobes and frame count.
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      hcount_r       <= 11'd0;
      vcount_r       <= 10'd0;
      hsync_r        <= ~SYNC_POL;
      vsync_r        <= ~SYNC_POL;
      blank_r        <= 1'b0;
      frame_start_r  <= 1'b0;
      vblank_start_r <= 1'b0;
      frame_count_r  <= 8'd0;
    end else begin
      hcount_r       <= hcount_next_s;
      vcount_r       <= vcount_next_s;
      hsync_r        <= in_window(hcount_next_s, HS_START_C, HS_END_C) ? SYNC_POL : ~SYNC_POL;
      vsync_r        <= in_window({1'b0, vcount_next_s}, VS_START_C, VS_END_C) ? SYNC_POL : ~SYNC_POL;
      blank_r        <= (hcount_next_s >= H_ACT_C) || (vcount_next_s >= V_ACT_C);
      frame_start_r  <= h_wrap_s && v_wrap_s;
      vblank_start_r <= (hcount_next_s == 11'd0) && (vcount_next_s == V_ACT_C);
      if (h_wrap_s && v_wrap_s) begin
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  sync_delay #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     (3),
    .RESET_VAL (FILL_C)
  ) u_sync_delay (
    .clk     (vclock),
    .reset_n (reset_n),
    .din     ({hsync_r, vsync_r, blank_r}),
    .dout    (delayed_s)
  );

  assign hcount       = hcount_r;
  assign vcount       = vcount_r;
  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign blank        = blank_r;
  assign hsync_d      = delayed_s[2];
  assign vsync_d      = delayed_s[1];
  assign blank_d      = delayed_s[0];
  assign frame_start  = frame_start_r;
  assign vblank_start = vblank_start_r;
  assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: three instances (default timing, default timing with
// no delay, and a tiny raster with active-high sync) compared every cycle
// against a reference computed from the cycle count since reset.
module tb_xvga_timing;

  // Tiny raster so whole frames and the 256-frame wrap fit in a short run.
  localparam int SH_A = 12, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_A = 4,  SV_F = 1, SV_S = 2, SV_B = 1;
  localparam int S_FRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
    bit fs;
    bit vbs;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;

  logic [10:0] a_h, b_h, c_h;
  logic [9:0]  a_v, b_v, c_v;
  logic a_hs, a_vs, a_bl, a_hsd, a_vsd, a_bld, a_fs, a_vbs;
  logic b_hs, b_vs, b_bl, b_hsd, b_vsd, b_bld, b_fs, b_vbs;
  logic c_hs, c_vs, c_bl, c_hsd, c_vsd, c_bld, c_fs, c_vbs;
  logic [7:0] a_fc, b_fc, c_fc;

  always #5 clk = ~clk;

  xvga_timing u_def (
    .vclock(clk), .reset_n(reset_n), .hcount(a_h), .vcount(a_v),
    .hsync(a_hs), .vsync(a_vs), .blank(a_bl), .hsync_d(a_hsd), .vsync_d(a_vsd),
    .blank_d(a_bld), .frame_start(a_fs), .vblank_start(a_vbs), .frame_count(a_fc)
  );

  xvga_timing #(.PIPE_DELAY(0)) u_p0 (
    .vclock(clk), .reset_n(reset_n), .hcount(b_h), .vcount(b_v),
    .hsync(b_hs), .vsync(b_vs), .blank(b_bl), .hsync_d(b_hsd), .vsync_d(b_vsd),
    .blank_d(b_bld), .frame_start(b_fs), .vblank_start(b_vbs), .frame_count(b_fc)
  );

  xvga_timing #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) u_small (
    .vclock(clk), .reset_n(reset_n), .hcount(c_h), .vcount(c_v),
    .hsync(c_hs), .vsync(c_vs), .blank(c_bl), .hsync_d(c_hsd), .vsync_d(c_vsd),
    .blank_d(c_bld), .frame_start(c_fs), .vblank_start(c_vbs), .frame_count(c_fc)
  );

  // Expected outputs n cycles after the reset state, from the raster rules.
  function automatic exp_t exp_at(input int n, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs,
                                  input int vb, input bit pol);
    exp_t e;
    int ht, vt, ft, pos;
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    ft    = ht * vt;
    pos   = n % ft;
    e.h   = pos % ht;
    e.v   = pos / ht;
    e.hs  = (e.h >= ha + hf && e.h < ha + hf + hs) ? pol : !pol;
    e.vs  = (e.v >= va + vf && e.v < va + vf + vs) ? pol : !pol;
    e.bl  = (e.h >= ha) || (e.v >= va);
    e.fs  = (n > 0) && (pos == 0);
    e.vbs = (pos == va * ht);
    e.fc  = (n / ft) % 256;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, expv);
    end
  endtask

  task automatic check_dut(input string nm, input int d,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb, input bit pol,
                           input logic [10:0] h, input logic [9:0] v,
                           input logic hsy, input logic vsy, input logic bl,
                           input logic hsd, input logic vsd, input logic bld,
                           input logic fs, input logic vbs, input logic [7:0] fc);
    exp_t e, ed;
    e = exp_at(k, ha, hf, hs, hb, va, vf, vs, vb, pol);
    if (k >= d) begin
      ed = exp_at(k - d, ha, hf, hs, hb, va, vf, vs, vb, pol);
    end else begin
      ed = e;
      ed.hs = !pol;
      ed.vs = !pol;
      ed.bl = 1'b1;
    end
    chk({nm, ".hcount"},       32'(h),   32'(e.h));
    chk({nm, ".vcount"},       32'(v),   32'(e.v));
    chk({nm, ".hsync"},        32'(hsy), 32'(e.hs));
    chk({nm, ".vsync"},        32'(vsy), 32'(e.vs));
    chk({nm, ".blank"},        32'(bl),  32'(e.bl));
    chk({nm, ".hsync_d"},      32'(hsd), 32'(ed.hs));
    chk({nm, ".vsync_d"},      32'(vsd), 32'(ed.vs));
    chk({nm, ".blank_d"},      32'(bld), 32'(ed.bl));
    chk({nm, ".frame_start"},  32'(fs),  32'(e.fs));
    chk({nm, ".vblank_start"}, 32'(vbs), 32'(e.vbs));
    chk({nm, ".frame_count"},  32'(fc),  32'(e.fc));
  endtask

  task automatic check_all();
    check_dut("def", 2, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0,
              a_h, a_v, a_hs, a_vs, a_bl, a_hsd, a_vsd, a_bld, a_fs, a_vbs, a_fc);
    check_dut("p0", 0, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0,
              b_h, b_v, b_hs, b_vs, b_bl, b_hsd, b_vsd, b_bld, b_fs, b_vbs, b_fc);
    check_dut("small", 3, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1,
              c_h, c_v, c_hs, c_vs, c_bl, c_hsd, c_vsd, c_bld, c_fs, c_vbs, c_fc);
  endtask

  // One clock with the given reset level, then compare after the edge settles.
  task automatic step(input logic rst_level);
    reset_n = rst_level;
    @(posedge clk);
    #1;
    if (!rst_level) begin
      k = 0;
    end else begin
      k = k + 1;
    end
    check_all();
  endtask

  initial begin
    int run_len;
    int rst_len;

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
    end

    // Random run lengths interrupted by random-length resets (mid-line / mid-frame).
    for (int p = 0; p < 6; p++) begin
      run_len = int'($urandom_range(30, 1500));
      rst_len = int'($urandom_range(1, 4));
      for (int i = 0; i < run_len; i++) begin
        step(1'b1);
      end
      for (int i = 0; i < rst_len; i++) begin
        step(1'b0);
      end
    end

    // Long uninterrupted run: several default lines and 257 tiny frames,
    // covering frame_count wrapping from 255 back to 0.
    run_len = 257 * S_FRAME + 3 * 1344 + int'($urandom_range(0, 200));
    for (int i = 0; i < run_len; i++) begin
      step(1'b1);
    end

    // Reset after the long run and resume.
    step(1'b0);
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      step(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
